peripheral_arbiter_wb: RTL and testbench



---
 rtl/peripheral_arbiter_wb.sv | 200 ++++++++++++++++++++
 tb/tb_peripheral_arbiter_wb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_arbiter_wb.sv
// peripheral_arbiter_wb
// Round-robin arbiter that shares one Wishbone B3 slave port between
// NUM_MASTERS Wishbone B3 masters. The winner owns the bus for its whole
// cyc window, so classic cycles and CTI/BTE bursts pass through unbroken.
// A per-grant watchdog ends a stalled strobe with a one-cycle error.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   m_*_i                 per-master request buses, master k in slice [k*W +: W]
//   m_dat_o               slave read data broadcast to every master
//   m_ack_o/err_o/rty_o   per-master responses (only the owner's bit can be set)
//   s_*_o                 slave-side request, muxed from the owner
//   s_dat_i, s_ack_i,
//   s_err_i, s_rty_i      slave read data and responses
//   grant_o               one-hot current owner, zero when idle
//
// Handshake: a beat completes on a cycle where s_stb_o is high and the
// slave returns ack, err or rty; the owner keeps the bus while its cyc
// is high, and releases it on the first edge that samples cyc low.
module peripheral_arbiter_wb #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NUM_MASTERS = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]      m_we_i,
  input  logic [NUM_MASTERS-1:0]      m_cyc_i,
  input  logic [NUM_MASTERS-1:0]      m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
  output logic [DW-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]      m_ack_o,
  output logic [NUM_MASTERS-1:0]      m_err_o,
  output logic [NUM_MASTERS-1:0]      m_rty_o,
  output logic [AW-1:0]               s_adr_o,
  output logic [DW-1:0]               s_dat_o,
  output logic [DW/8-1:0]             s_sel_o,
  output logic                        s_we_o,
  output logic                        s_cyc_o,
  output logic                        s_stb_o,
  output logic [2:0]                  s_cti_o,
  output logic [1:0]                  s_bte_o,
  input  logic [DW-1:0]               s_dat_i,
  input  logic                        s_ack_i,
  input  logic                        s_err_i,
  input  logic                        s_rty_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int SW  = DW / 8;
  localparam int PW  = $clog2(NUM_MASTERS);
  // A zero TIMEOUT disables the watchdog; keep a 1-bit counter so the
  // declaration stays legal.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TERR = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [WDW-1:0]         wd_q, wd_d;

  logic                   own_cyc;
  logic                   own_stb;
  logic                   stall;
  logic                   found;
  logic [PW-1:0]          win_idx;
  logic [NUM_MASTERS-1:0] win_oh;

  // Request mux: AND-OR select on the registered one-hot grant. With no
  // grant (idle or reset) every slave-side field collapses to zero.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      s_adr_o = s_adr_o | (m_adr_i[k*AW +: AW] & {AW{grant_q[k]}});
      s_dat_o = s_dat_o | (m_dat_i[k*DW +: DW] & {DW{grant_q[k]}});
      s_sel_o = s_sel_o | (m_sel_i[k*SW +: SW] & {SW{grant_q[k]}});
      s_cti_o = s_cti_o | (m_cti_i[k*3 +: 3]   & {3{grant_q[k]}});
      s_bte_o = s_bte_o | (m_bte_i[k*2 +: 2]   & {2{grant_q[k]}});
      s_we_o  = s_we_o  | (m_we_i[k]  & grant_q[k]);
      own_cyc = own_cyc | (m_cyc_i[k] & grant_q[k]);
      own_stb = own_stb | (m_stb_i[k] & grant_q[k]);
    end
  end

  // cyc/stb reach the slave only while owning; TERR forces them low.
  assign s_cyc_o = (state_q == OWN) & own_cyc;
  assign s_stb_o = (state_q == OWN) & own_stb;

  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

  assign m_ack_o = (state_q == OWN) ? (grant_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_rty_o = (state_q == OWN) ? (grant_q & {NUM_MASTERS{s_rty_i}}) : '0;
  assign m_err_o = (state_q == OWN)  ? (grant_q & {NUM_MASTERS{s_err_i}}) :
                   (state_q == TERR) ? grant_q : '0;

  assign stall = (state_q == OWN) & own_stb & ~(s_ack_i | s_err_i | s_rty_i);

  // Circular search for the first requester at or after rr_ptr.
  always_comb begin
    int            j;
    logic [PW-1:0] j_idx;
    found   = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    j       = 0;
    j_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      j_idx = PW'(j);
      if (!found && m_cyc_i[j_idx]) begin
        found   = 1'b1;
        win_idx = j_idx;
      end
    end
    if (found) win_oh[win_idx] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    wd_d     = wd_q;
    unique case (state_q)
      IDLE: begin
        wd_d = '0;
        if (found) begin
          grant_d  = win_oh;
          // Pointer moves past the winner at grant time, so a TERR exit
          // already rotates priority.
          rr_ptr_d = (int'(win_idx) == NUM_MASTERS - 1) ? '0 : win_idx + PW'(1);
          state_d  = OWN;
        end
      end
      OWN: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
          wd_d    = '0;
        end else if (stall && (TIMEOUT > 0)) begin
          if (wd_q == WD_LAST) begin
            state_d = TERR;
            wd_d    = '0;
          end else begin
            wd_d = wd_q + WDW'(1);
          end
        end else begin
          // Any response (including one on the last allowed cycle) or a
          // dropped strobe restarts the count.
          wd_d = '0;
        end
      end
      TERR: begin
        state_d = IDLE;
        grant_d = '0;
        wd_d    = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wd_q     <= wd_d;
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Directed bench for peripheral_arbiter_wb (4 masters, TIMEOUT=8).
// Inputs change 1 time unit after a rising edge; outputs are checked a
// couple of time units later, well clear of the next edge.
module tb_peripheral_arbiter_wb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*DW/8-1:0] m_sel_i;
  logic [N-1:0]      m_we_i, m_cyc_i, m_stb_i;
  logic [N*3-1:0]    m_cti_i;
  logic [N*2-1:0]    m_bte_i;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;
  logic [N-1:0]      grant_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  peripheral_arbiter_wb #(
    .AW(AW), .DW(DW), .NUM_MASTERS(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_m(input int k, input logic cyc, input logic stb,
                       input logic we, input logic [2:0] cti);
    m_cyc_i[k]         = cyc;
    m_stb_i[k]         = stb;
    m_we_i[k]          = we;
    m_cti_i[k*3 +: 3]  = cti;
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // ---------------- reset ----------------
    rst_n   = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_cti_i = '0;
    m_bte_i = '0;
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*AW +: AW] = 32'hA000_0000 + 32'(k) * 32'h100;
      m_dat_i[k*DW +: DW] = 32'hD000_0000 + 32'(k);
      m_sel_i[k*4 +: 4]   = 4'(k + 1);
    end
    m_bte_i[2 +: 2] = 2'b01;
    s_dat_i = 32'hCAFE_F00D;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
    #2;
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_m_dat", m_dat_o, 32'hCAFE_F00D);
    step();
    step();
    rst_n = 1'b1;

    // ---------------- masters 1 and 3 together ----------------
    set_m(1, 1'b1, 1'b1, 1'b1, 3'b000);
    set_m(3, 1'b1, 1'b1, 1'b0, 3'b000);
    step();
    s_ack_i = 1'b1;
    settle();
    chk("t1_grant1", 32'(grant_o), 32'b0010);
    chk("t1_s_cyc", 32'(s_cyc_o), 32'h1);
    chk("t1_s_adr", s_adr_o, 32'hA000_0100);
    chk("t1_s_dat", s_dat_o, 32'hD000_0001);
    chk("t1_s_sel", 32'(s_sel_o), 32'h2);
    chk("t1_s_we", 32'(s_we_o), 32'h1);
    chk("t1_s_bte", 32'(s_bte_o), 32'h1);
    chk("t1_ack", 32'(m_ack_o), 32'b0010);
    step();
    s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, 3'b000);
    settle();
    chk("t1_hold_grant", 32'(grant_o), 32'b0010);
    chk("t1_ack_off", 32'(m_ack_o), 32'h0);
    step();
    chk("t1_gap_grant", 32'(grant_o), 32'h0);
    chk("t1_gap_s_cyc", 32'(s_cyc_o), 32'h0);
    step();
    chk("t1_grant3", 32'(grant_o), 32'b1000);
    set_m(3, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    chk("t1_idle", 32'(grant_o), 32'h0);

    // ---------------- four masters, order 0,1,2,3,0 ----------------
    for (int k = 0; k < N; k++) set_m(k, 1'b1, 1'b1, 1'b0, 3'b000);
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int n = 0; n < 5; n++) begin
        step();
        s_ack_i = 1'b1;
        settle();
        chk("t2_grant", 32'(grant_o), 32'(1) << order[n]);
        chk("t2_ack", 32'(m_ack_o), 32'(1) << order[n]);
        step();
        s_ack_i = 1'b0;
        set_m(order[n], 1'b0, 1'b0, 1'b0, 3'b000);
        settle();
        chk("t2_ack_off", 32'(m_ack_o), 32'h0);
        step();
        chk("t2_gap", 32'(grant_o), 32'h0);
        if (n < 4) set_m(order[n], 1'b1, 1'b1, 1'b0, 3'b000);
      end
    end
    for (int k = 0; k < N; k++) set_m(k, 1'b0, 1'b0, 1'b0, 3'b000);
    step();

    // ---------------- 8-beat burst on master 2, master 0 waiting ----------------
    set_m(2, 1'b1, 1'b1, 1'b0, 3'b010);
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b000);
    step();
    s_ack_i = 1'b1;
    for (int b = 0; b < 8; b++) begin
      set_m(2, 1'b1, 1'b1, 1'b0, (b == 7) ? 3'b111 : 3'b010);
      settle();
      chk("t3_grant", 32'(grant_o), 32'b0100);
      chk("t3_ack", 32'(m_ack_o), 32'b0100);
      chk("t3_cti", 32'(s_cti_o), (b == 7) ? 32'h7 : 32'h2);
      step();
    end
    set_m(2, 1'b0, 1'b0, 1'b0, 3'b000);
    s_ack_i = 1'b0;
    settle();
    chk("t3_ack_off", 32'(m_ack_o), 32'h0);
    chk("t3_hold", 32'(grant_o), 32'b0100);
    step();
    chk("t3_gap", 32'(grant_o), 32'h0);
    step();
    chk("t3_grant0", 32'(grant_o), 32'b0001);
    set_m(0, 1'b0, 1'b0, 1'b0, 3'b000);
    step();

    // ---------------- watchdog expiry on master 1 ----------------
    set_m(1, 1'b1, 1'b1, 1'b0, 3'b000);
    set_m(2, 1'b1, 1'b1, 1'b0, 3'b000);
    step();
    chk("t4_grant1", 32'(grant_o), 32'b0010);
    for (int i = 1; i <= TO; i++) begin
      chk("t4_no_err", 32'(m_err_o), 32'h0);
      chk("t4_s_cyc", 32'(s_cyc_o), 32'h1);
      step();
    end
    chk("t4_err", 32'(m_err_o), 32'b0010);
    chk("t4_terr_cyc", 32'(s_cyc_o), 32'h0);
    chk("t4_terr_stb", 32'(s_stb_o), 32'h0);
    chk("t4_terr_grant", 32'(grant_o), 32'b0010);
    chk("t4_terr_ack", 32'(m_ack_o), 32'h0);
    step();
    chk("t4_err_once", 32'(m_err_o), 32'h0);
    chk("t4_idle", 32'(grant_o), 32'h0);
    step();
    chk("t4_rotate", 32'(grant_o), 32'b0100);
    set_m(1, 1'b0, 1'b0, 1'b0, 3'b000);
    set_m(2, 1'b0, 1'b0, 1'b0, 3'b000);
    step();

    // ---------------- ack on the last allowed stall cycle ----------------
    set_m(3, 1'b1, 1'b1, 1'b0, 3'b000);
    step();
    chk("t5_grant3", 32'(grant_o), 32'b1000);
    for (int i = 1; i < TO; i++) begin
      chk("t5_stall_ack", 32'(m_ack_o), 32'h0);
      chk("t5_stall_err", 32'(m_err_o), 32'h0);
      step();
    end
    s_ack_i = 1'b1;
    settle();
    chk("t5_ack", 32'(m_ack_o), 32'b1000);
    chk("t5_no_err", 32'(m_err_o), 32'h0);
    step();
    s_ack_i = 1'b0;
    settle();
    chk("t5_no_terr", 32'(m_err_o), 32'h0);
    chk("t5_still_own", 32'(grant_o), 32'b1000);
    chk("t5_s_cyc", 32'(s_cyc_o), 32'h1);
    step();
    chk("t5_no_err2", 32'(m_err_o), 32'h0);
    set_m(3, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    chk("t5_idle", 32'(grant_o), 32'h0);

    // ---------------- asynchronous reset mid-burst ----------------
    set_m(2, 1'b1, 1'b1, 1'b1, 3'b010);
    step();
    chk("t6_grant2", 32'(grant_o), 32'b0100);
    s_ack_i = 1'b1;
    step();
    step();
    settle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(grant_o), 32'h0);
    chk("t6_rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("t6_rst_s_stb", 32'(s_stb_o), 32'h0);
    chk("t6_rst_s_adr", s_adr_o, 32'h0);
    chk("t6_rst_s_we", 32'(s_we_o), 32'h0);
    chk("t6_rst_s_cti", 32'(s_cti_o), 32'h0);
    chk("t6_rst_ack", 32'(m_ack_o), 32'h0);
    s_dat_i = 32'h1234_5678;
    set_m(2, 1'b0, 1'b0, 1'b0, 3'b000);
    s_ack_i = 1'b0;
    #1;
    chk("t6_rst_m_dat", m_dat_o, 32'h1234_5678);
    #1;
    rst_n = 1'b1;
    set_m(1, 1'b1, 1'b1, 1'b0, 3'b000);
    set_m(3, 1'b1, 1'b1, 1'b0, 3'b000);
    step();
    chk("t6_rr_reset", 32'(grant_o), 32'b0010);
    set_m(1, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    chk("t6_gap", 32'(grant_o), 32'h0);
    step();
    chk("t6_grant3", 32'(grant_o), 32'b1000);
    set_m(3, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    chk("t6_idle", 32'(grant_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
